// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, forwarding, redirect and perf-counter control for the
// 5-stage RV32I pipeline.
// Inputs : stage register indices (rs1D/rs2D/rs1E/rs2E/rdE/rdM/rdW), stage
//          control bits (regWriteM/W, memReadE), branch resolve (pcsrcE),
//          stall sources (icacheStall, dcacheStall, exBusy), perfClr.
// Outputs: EX/ID forwarding selects, per-stage stall/flush, fetch redirect
//          controls (redirectF, useSavedTarget, captureTarget) and three
//          saturating performance counters (registered).
module pipeline_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned CNT_WIDTH        = 32,
  parameter bit          DCACHE_BUBBLE_WB = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] rdE,
  input  logic [REG_ADDR_WIDTH-1:0] rdM,
  input  logic [REG_ADDR_WIDTH-1:0] rdW,
  input  logic                      regWriteM,
  input  logic                      regWriteW,
  input  logic                      memReadE,
  input  logic                      pcsrcE,
  input  logic                      icacheStall,
  input  logic                      dcacheStall,
  input  logic                      exBusy,
  input  logic                      perfClr,
  output logic [1:0]                forwardAE,
  output logic [1:0]                forwardBE,
  output logic                      forwardAD,
  output logic                      forwardBD,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      stallE,
  output logic                      stallM,
  output logic                      flushD,
  output logic                      flushE,
  output logic                      flushM,
  output logic                      flushW,
  output logic                      redirectF,
  output logic                      useSavedTarget,
  output logic                      captureTarget,
  output logic [CNT_WIDTH-1:0]      stallCycles,
  output logic [CNT_WIDTH-1:0]      flushCount,
  output logic [CNT_WIDTH-1:0]      loadUseCount
);

  localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

  logic                 r_pending;
  logic                 w_load_use;
  logic                 w_redirect;
  logic                 w_release;
  logic                 w_row_redirect;
  logic                 w_row_load_use;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_flush_count;
  logic [CNT_WIDTH-1:0] r_load_use_count;

  // EX operand select: MEM result beats WB result
  function automatic logic [1:0] fwd_ex(input logic [REG_ADDR_WIDTH-1:0] rs);
    if (regWriteM && (rdM != X0) && (rdM == rs))      return 2'b10;
    else if (regWriteW && (rdW != X0) && (rdW == rs)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  // Operand forwarding
  always_comb begin
    forwardAE = fwd_ex(rs1E);
    forwardBE = fwd_ex(rs2E);
    forwardAD = regWriteW && (rdW != X0) && (rdW == rs1D);
    forwardBD = regWriteW && (rdW != X0) && (rdW == rs2D);
  end

  // Hazard condition terms; a held EX keeps pcsrcE alive, so redirect simply waits
  assign w_load_use = memReadE && (rdE != X0) && ((rdE == rs1D) || (rdE == rs2D));
  assign w_redirect = pcsrcE && !dcacheStall && !exBusy;
  // A younger redirect recaptures instead, so the saved target is only used when no new one arrives
  assign w_release  = r_pending && !icacheStall && !dcacheStall && !w_redirect;

  // Prioritised stall/flush and fetch redirect control
  always_comb begin
    stallF         = 1'b0;
    stallD         = 1'b0;
    stallE         = 1'b0;
    stallM         = 1'b0;
    flushD         = 1'b0;
    flushE         = 1'b0;
    flushM         = 1'b0;
    flushW         = 1'b0;
    redirectF      = 1'b0;
    useSavedTarget = 1'b0;
    captureTarget  = 1'b0;
    w_row_redirect = 1'b0;
    w_row_load_use = 1'b0;

    if (dcacheStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = DCACHE_BUBBLE_WB;
    end else if (exBusy) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (w_redirect) begin
      w_row_redirect = 1'b1;
      flushD         = 1'b1;
      flushE         = 1'b1;
      if (icacheStall || r_pending) begin
        captureTarget = 1'b1;
        stallF        = icacheStall;
      end else begin
        redirectF = 1'b1;
      end
    end else if (w_load_use) begin
      w_row_load_use = 1'b1;
      stallF         = 1'b1;
      stallD         = 1'b1;
      flushE         = 1'b1;
    end else if (icacheStall) begin
      stallF = 1'b1;
      flushD = 1'b1;
    end

    // Fetch was parked on the wrong path; drop what it delivers this cycle unless decode is held
    if (w_release) begin
      redirectF      = 1'b1;
      useSavedTarget = 1'b1;
      if (!stallD) flushD = 1'b1;
    end
  end

  // Pending redirect latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               r_pending <= 1'b0;
    else if (captureTarget) r_pending <= 1'b1;
    else if (w_release)     r_pending <= 1'b0;
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles   <= '0;
      r_flush_count    <= '0;
      r_load_use_count <= '0;
    end else if (perfClr) begin
      r_stall_cycles   <= '0;
      r_flush_count    <= '0;
      r_load_use_count <= '0;
    end else begin
      if (stallF && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      if (w_row_redirect && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_WIDTH'(1);
      if (w_row_load_use && (r_load_use_count != '1))
        r_load_use_count <= r_load_use_count + CNT_WIDTH'(1);
    end
  end

  assign stallCycles  = r_stall_cycles;
  assign flushCount   = r_flush_count;
  assign loadUseCount = r_load_use_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver applies one directed vector per
// cycle and queues the hand-computed response; a monitor compares mid-cycle.
module tb_pipeline_ctrl;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic          regWriteM, regWriteW, memReadE, pcsrcE;
  logic          icacheStall, dcacheStall, exBusy, perfClr;

  logic [1:0]  forwardAE, forwardBE;
  logic        forwardAD, forwardBD;
  logic        stallF, stallD, stallE, stallM;
  logic        flushD, flushE, flushM, flushW;
  logic        redirectF, useSavedTarget, captureTarget;
  logic [31:0] stallCycles, flushCount, loadUseCount;

  logic [1:0]  q_forwardAE, q_forwardBE;
  logic        q_forwardAD, q_forwardBD;
  logic        q_stallF, q_stallD, q_stallE, q_stallM;
  logic        q_flushD, q_flushE, q_flushM, q_flushW;
  logic        q_redirectF, q_useSavedTarget, q_captureTarget;
  logic [3:0]  q_stallCycles, q_flushCount, q_loadUseCount;

  always #5 clk = ~clk;

  pipeline_ctrl u_dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .memReadE(memReadE),
    .pcsrcE(pcsrcE), .icacheStall(icacheStall), .dcacheStall(dcacheStall),
    .exBusy(exBusy), .perfClr(perfClr),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .redirectF(redirectF), .useSavedTarget(useSavedTarget),
    .captureTarget(captureTarget),
    .stallCycles(stallCycles), .flushCount(flushCount),
    .loadUseCount(loadUseCount)
  );

  // Narrow-counter, hold-WB variant sharing the same inputs
  pipeline_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(4), .DCACHE_BUBBLE_WB(1'b0)) u_dut4 (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .memReadE(memReadE),
    .pcsrcE(pcsrcE), .icacheStall(icacheStall), .dcacheStall(dcacheStall),
    .exBusy(exBusy), .perfClr(perfClr),
    .forwardAE(q_forwardAE), .forwardBE(q_forwardBE),
    .forwardAD(q_forwardAD), .forwardBD(q_forwardBD),
    .stallF(q_stallF), .stallD(q_stallD), .stallE(q_stallE), .stallM(q_stallM),
    .flushD(q_flushD), .flushE(q_flushE), .flushM(q_flushM), .flushW(q_flushW),
    .redirectF(q_redirectF), .useSavedTarget(q_useSavedTarget),
    .captureTarget(q_captureTarget),
    .stallCycles(q_stallCycles), .flushCount(q_flushCount),
    .loadUseCount(q_loadUseCount)
  );

  // ctl = {fwdAE,fwdBE, fwdAD,fwdBD, stallF,D,E,M, flushD,E,M,W, redirectF,useSaved,capture}
  typedef struct {
    string       name;
    logic [16:0] ctl;
    int          sc;
    int          fc;
    int          lc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare the oldest expectation against the DUT mid-cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] act;
    int          sc4;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {forwardAE, forwardBE, forwardAD, forwardBD,
             stallF, stallD, stallE, stallM,
             flushD, flushE, flushM, flushW,
             redirectF, useSavedTarget, captureTarget};
      sc4 = (e.sc > 15) ? 15 : e.sc;
      chk({e.name, ".ctl"}, 64'(act), 64'(e.ctl));
      chk({e.name, ".stallCycles"}, 64'(stallCycles), 64'(e.sc));
      chk({e.name, ".flushCount"}, 64'(flushCount), 64'(e.fc));
      chk({e.name, ".loadUseCount"}, 64'(loadUseCount), 64'(e.lc));
      chk({e.name, ".sat4.stallCycles"}, 64'(q_stallCycles), 64'(sc4));
      chk({e.name, ".holdwb.flushW"}, 64'(q_flushW), 64'(0));
    end
  end

  // Queue the expectation for the inputs just applied, then advance to the next cycle
  task automatic step(input string nm, input logic [16:0] ctl,
                      input int sc, input int fc, input int lc);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.sc = sc; e.fc = fc; e.lc = lc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    regWriteM = 1'b0; regWriteW = 1'b0; memReadE = 1'b0; pcsrcE = 1'b0;
    icacheStall = 1'b0; dcacheStall = 1'b0; exBusy = 1'b0; perfClr = 1'b0;
  endtask

  localparam logic [16:0] IDLE    = 17'b00_00_00_0000_0000_000;
  localparam logic [16:0] LOADUSE = 17'b00_00_00_1100_0100_000;
  localparam logic [16:0] DSTALL  = 17'b00_00_00_1111_0001_000;
  localparam logic [16:0] CAPT_IC = 17'b00_00_00_1000_1100_001;
  localparam logic [16:0] ICSTALL = 17'b00_00_00_1000_1000_000;
  localparam logic [16:0] RELEASE = 17'b00_00_00_0000_1000_110;
  localparam logic [16:0] EXBUSY  = 17'b00_00_00_1110_0010_000;

  initial begin
    rst = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    step("reset", IDLE, 0, 0, 0);
    rst = 1'b1;
    step("idle", IDLE, 0, 0, 0);

    // Forwarding
    rdM = 5; rdW = 5; regWriteM = 1'b1; regWriteW = 1'b1; rs1E = 5;
    step("fwd_mem", 17'b10_00_00_0000_0000_000, 0, 0, 0);
    regWriteM = 1'b0; rs2E = 5; rs1D = 5;
    step("fwd_wb", 17'b01_01_10_0000_0000_000, 0, 0, 0);
    rdW = 0; rs1E = 0; rs2E = 0; rs1D = 0;
    step("fwd_x0", IDLE, 0, 0, 0);
    rdM = 3; regWriteM = 1'b1; rdW = 3; rs2E = 3; rs2D = 3;
    step("fwd_prio", 17'b00_10_01_0000_0000_000, 0, 0, 0);
    clear_inputs();

    // Load-use
    memReadE = 1'b1; rdE = 7; rs2D = 7;
    step("loaduse", LOADUSE, 0, 0, 0);
    rdE = 0;
    step("loaduse_x0", IDLE, 1, 0, 1);
    clear_inputs();

    // D-cache stall holding a resolved branch
    dcacheStall = 1'b1; pcsrcE = 1'b1;
    for (int i = 0; i < 4; i++) step("dstall", DSTALL, 1 + i, 0, 1);
    dcacheStall = 1'b0;
    step("dstall_redirect", 17'b00_00_00_0000_1100_100, 5, 0, 1);
    pcsrcE = 1'b0;
    step("post_redirect", IDLE, 5, 1, 1);

    // Redirect captured under an I-cache stall
    pcsrcE = 1'b1; icacheStall = 1'b1;
    step("capture", CAPT_IC, 5, 1, 1);
    pcsrcE = 1'b0;
    step("pending_ic0", ICSTALL, 6, 2, 1);
    step("pending_ic1", ICSTALL, 7, 2, 1);
    icacheStall = 1'b0;
    step("release", RELEASE, 8, 2, 1);
    step("release_done", IDLE, 8, 2, 1);

    // Younger redirect overwrites a pending one
    pcsrcE = 1'b1; icacheStall = 1'b1;
    step("capture2", CAPT_IC, 8, 2, 1);
    icacheStall = 1'b0;
    step("recapture", 17'b00_00_00_0000_1100_001, 9, 3, 1);
    pcsrcE = 1'b0;
    step("release2", RELEASE, 9, 4, 1);
    step("release2_done", IDLE, 9, 4, 1);

    // EX busy, then with a load-use hidden behind it
    exBusy = 1'b1;
    step("exbusy", EXBUSY, 9, 4, 1);
    memReadE = 1'b1; rdE = 7; rs1D = 7;
    step("exbusy_loaduse", EXBUSY, 10, 4, 1);
    exBusy = 1'b0;
    step("loaduse_after_ex", LOADUSE, 11, 4, 1);
    clear_inputs();
    step("idle2", IDLE, 12, 4, 2);

    // Reset while a redirect is pending
    pcsrcE = 1'b1; icacheStall = 1'b1;
    step("capture3", CAPT_IC, 12, 4, 2);
    pcsrcE = 1'b0; rst = 1'b0;
    step("reset_pending", ICSTALL, 0, 0, 0);
    rst = 1'b1; icacheStall = 1'b0;
    step("no_release", IDLE, 0, 0, 0);

    // Saturation of the 4-bit counter and clear priority
    icacheStall = 1'b1;
    for (int i = 0; i < 20; i++) step("sat", ICSTALL, i, 0, 0);
    perfClr = 1'b1;
    step("clr", ICSTALL, 20, 0, 0);
    clear_inputs();
    step("cleared", IDLE, 0, 0, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
